// File: rtl/muldiv_seq_if.sv
// Execute-stage request/response bundle for the multiply/divide sequencer.
// master = execute stage, slave = sequencer.
interface muldiv_seq_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        op_ready;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op_valid, op, rs_val, rt_val, flush,
    input  op_ready, busy, done, div_by_zero, hi, lo
  );
  modport slave (
    input  op_valid, op, rs_val, rt_val, flush,
    output op_ready, busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// MIPS HI/LO owner: sequences an internal multiply and an external combinational
// divider as fixed multicycle paths, plus MTHI/MTLO writes.
module muldiv_seq #(
  parameter int DIV_CYCLES = 8,
  parameter int MUL_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_seq_if.slave  bus,
  output logic [31:0]  div_a,
  output logic [31:0]  div_b,
  output logic         div_signed,
  input  logic [31:0]  div_q,
  input  logic [31:0]  div_r
);
  localparam int MAXC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
  } mulop_t;

  state_t      state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [31:0] hi_q, hi_n, lo_q, lo_n, da_q, da_n, db_q, db_n;
  logic        ds_q, ds_n, done_q, done_n, dbz_q, dbz_n;
  mulop_t      mop_q, mop_n;
  logic [63:0] ext_a, ext_b, prod;

  // Extending both operands to 64 bits makes one truncated multiply serve both modes.
  assign ext_a = {{32{mop_q.sgn & mop_q.a[31]}}, mop_q.a};
  assign ext_b = {{32{mop_q.sgn & mop_q.b[31]}}, mop_q.b};
  assign prod  = ext_a * ext_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      da_q    <= '0;
      db_q    <= '0;
      ds_q    <= 1'b1;
      mop_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
      da_q    <= da_n;
      db_q    <= db_n;
      ds_q    <= ds_n;
      mop_q   <= mop_n;
      done_q  <= done_n;
      dbz_q   <= dbz_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    hi_n    = hi_q;
    lo_n    = lo_q;
    da_n    = da_q;
    db_n    = db_q;
    ds_n    = ds_q;
    mop_n   = mop_q;
    done_n  = 1'b0;
    dbz_n   = 1'b0;
    if (bus.flush) begin
      // Flush beats both the in-flight op and any same-cycle request.
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state_q)
        IDLE: if (bus.op_valid) begin
          case (bus.op)
            3'b000, 3'b001: begin
              mop_n   = '{a: bus.rs_val, b: bus.rt_val, sgn: ~bus.op[0]};
              cnt_n   = CW'(MUL_CYCLES - 1);
              state_n = MUL;
            end
            3'b010, 3'b011: begin
              if (bus.rt_val == 32'd0) begin
                dbz_n = 1'b1;
              end else begin
                da_n    = bus.rs_val;
                db_n    = bus.rt_val;
                ds_n    = ~bus.op[0];
                cnt_n   = CW'(DIV_CYCLES - 1);
                state_n = DIV;
              end
            end
            3'b100:  hi_n = bus.rs_val;
            3'b101:  lo_n = bus.rs_val;
            default: ;
          endcase
        end
        MUL: begin
          if (cnt_q != '0) begin
            cnt_n = cnt_q - 1'b1;
          end else begin
            {hi_n, lo_n} = prod;
            done_n       = 1'b1;
            state_n      = IDLE;
          end
        end
        DIV: begin
          if (cnt_q != '0) begin
            cnt_n = cnt_q - 1'b1;
          end else begin
            lo_n    = div_q;
            hi_n    = div_r;
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.op_ready    = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign div_a           = da_q;
  assign div_b           = db_q;
  assign div_signed      = ds_q;
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multiply/divide sequencer for the MIPS54 core: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage, owns the architectural HI/LO registers and sequences the shared combinational divider as a fixed multicycle path. The divider's operands are held stable for DIV_CYCLES cycles before its quotient and remainder are captured. The multiply is computed internally and likewise held for MUL_CYCLES cycles. `busy` stalls the pipeline on HI/LO hazards.

## Interface
- DIV_CYCLES, 8, cycles operands are held on the divider before capture (>=1)
- MUL_CYCLES, 2, cycles operands are held on the multiplier before capture (>=1)
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- op_valid  in  1  operation request
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved
- rs_val  in  32  operand A (dividend / multiplicand / MTHI-MTLO data)
- rt_val  in  32  operand B (divisor / multiplier)
- flush  in  1  abort in-flight and same-cycle request
- op_ready  out  1  = (state==IDLE); request accepted when op_valid&&op_ready&&!flush
- busy  out  1  = (state!=IDLE)
- done  out  1  one-cycle pulse after HI/LO written by MUL/DIV
- div_by_zero  out  1  one-cycle pulse after a DIV/DIVU with rt_val==0 is accepted
- div_a  out  32  latched dividend to divider
- div_b  out  32  latched divisor to divider
- div_signed  out  1  1 for DIV, 0 for DIVU
- div_q  in  32  divider quotient (combinational from div_a/div_b)
- div_r  in  32  divider remainder
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, MUL, DIV. Down-counter cnt, width ceil(log2(max(DIV_CYCLES,MUL_CYCLES)))+1.
- IDLE, accept MTHI: hi<=rs_val; MTLO: lo<=rs_val; stay IDLE; no done.
- IDLE, accept reserved op: no state/register change.
- IDLE, accept MULT/MULTU: latch rs_val/rt_val and sign mode into internal op regs, cnt<=MUL_CYCLES-1, ->MUL.
- MUL: product = 64-bit product of latched operands (signed: both sign-extended to 64; unsigned: zero-extended). cnt!=0: cnt--. cnt==0: {hi,lo}<=product, done<=1, ->IDLE.
- IDLE, accept DIV/DIVU with rt_val!=0: div_a<=rs_val, div_b<=rt_val, div_signed<=~op[0], cnt<=DIV_CYCLES-1, ->DIV.
- DIV: cnt!=0: cnt--. cnt==0: lo<=div_q, hi<=div_r, done<=1, ->IDLE. div_a/div_b/div_signed never change while in DIV.
- DIV/DIVU with rt_val==0: accepted, HI/LO unchanged, state stays IDLE, div_by_zero<=1, div_a/div_b not updated.
- Signed divide contract (divider side): quotient truncates toward zero, remainder takes dividend sign; 0x80000000/-1 yields q=0x80000000, r=0.
- flush=1: state->IDLE, cnt<=0, HI/LO unchanged, done<=0; a same-cycle request is dropped (flush wins over accept).
- op_valid while busy: not accepted; requester holds it (no queueing).

## Timing
- Reset (reset==0): state=IDLE, hi=lo=0, div_a=div_b=0, div_signed=1, cnt=0, done=0, div_by_zero=0; op_ready=1, busy=0.
- Accept at edge E0: busy high from E0. MUL writes HI/LO at edge E0+MUL_CYCLES; DIV at E0+DIV_CYCLES.
- done and op_ready rise together after the writing edge; done high exactly one cycle.
- A new op can be accepted in the cycle done is high (back-to-back, zero bubble).
- MTHI/MTLO: hi/lo visible the cycle after acceptance; back-to-back MTHI/MTLO every cycle.
- div_by_zero: high for the one cycle following acceptance.
- Reset deasserted mid-operation: the operation is lost; outputs take reset values immediately (asynchronous).
- With DIV_CYCLES=1 / MUL_CYCLES=1: capture on the first edge after acceptance, busy high for exactly one cycle.

## Test plan
- MULT rs=0xFFFFFFFF rt=0x00000002 -> after MUL_CYCLES: hi=0xFFFFFFFF lo=0xFFFFFFFE, done pulse; MULTU same operands -> hi=0x00000001 lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7) rt=0x00000002 -> div_signed=1, busy for 8 cycles, lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU rs=7 rt=2 -> lo=3 hi=1.
- DIV rt=0 with hi=0x11111111 lo=0x22222222 -> div_by_zero one cycle, busy never set, hi/lo unchanged.
- MTHI 0xDEADBEEF then MTLO 0x12345678 on consecutive cycles -> hi/lo updated in successive cycles; then op_valid held during a DIV -> op_ready=0, accepted on the done cycle.
- DIV in flight, flush at cycle 3 -> IDLE next cycle, hi/lo keep prior values, no done; flush with simultaneous op_valid -> op dropped.
- reset driven to 0 mid-MULT -> hi=lo=0, busy=0, op_ready=1 immediately; no done after release.
